// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: word width, NOP encoding, reset PC, fetch states.
// Queue entry layout gains a fault bit when FETCH_ALIGN_TRAP_EN is defined.
// Pure declarations; no timing or flow control lives here.
package fetch_unit_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
`ifdef FETCH_ALIGN_TRAP_EN
        logic            fault;
`endif
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } qentry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous DEPTH-entry FIFO with push, pop, flush and occupancy count.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none internally; callers must never push when full or pop when empty.
module fetch_queue #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head_dat,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Flush wins over any same-cycle push or pop.
    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers words for decode.
// Latency: response to out_valid 1 cycle; redirect to first new request 1 cycle.
// Backpressure: out_ready stalls the queue; credits stop requests. FETCH_ALIGN_TRAP_EN adds misalignment traps.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
`ifdef FETCH_ALIGN_TRAP_EN
    output logic            out_fault,
`endif
    output logic [XLEN-1:0] out_pc4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;

    logic [CW-1:0]   w_q_count;
    logic [CW-1:0]   w_tag_cnt_unused;
    logic [XLEN-1:0] w_tag_head;
    qentry_t         w_q_head;
    qentry_t         w_push_ent;
    logic            w_q_push;
    logic            w_credit;
    logic            w_run;
    logic            w_fire;
    logic            w_resp;
    logic            w_resp_keep;
    logic            w_pop;
    logic [CW-1:0]   w_outst_nxt;

    // Queued plus in-flight words may never exceed the queue depth.
    assign w_credit       = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
    assign imem_req_valid = reset && w_credit && !redirect && w_run;
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    assign w_resp      = imem_resp_valid && (r_outstanding != '0);
    assign w_resp_keep = w_resp && (r_discard == '0) && !redirect && w_run;
    assign w_outst_nxt = r_outstanding + CW'(w_fire) - CW'(w_resp);

    assign out_valid = (w_q_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_instr = out_valid ? w_q_head.instr : INSTR_NOP;
    assign out_pc4   = out_valid ? w_q_head.pc4   : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outst_nxt;
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_discard  <= w_outst_nxt;
            end else begin
                if (w_fire) r_fetch_pc <= pc_next(r_fetch_pc);
                if (w_resp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
            end
        end
    end

`ifdef FETCH_ALIGN_TRAP_EN
    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_fault_pend;
    logic [XLEN-1:0] r_fault_pc4;
    logic            w_misalign;
    logic            w_fault_push;

    assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fault_push = 1'b0;
        if (redirect) begin
            w_state_nxt = w_misalign ? FAULT : RUN;
        end else if ((r_state == FAULT) && r_fault_pend && (r_discard == '0)) begin
            w_fault_push = 1'b1;
        end
    end

    // One synthetic NOP carries the fault once the old stream has drained.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fault_pend <= 1'b0;
            r_fault_pc4  <= '0;
        end else if (redirect) begin
            r_fault_pend <= w_misalign;
            r_fault_pc4  <= redirect_pc + 32'd4;
        end else if (w_fault_push) begin
            r_fault_pend <= 1'b0;
        end
    end

    assign w_run     = (r_state == RUN);
    assign w_q_push  = w_resp_keep || w_fault_push;
    assign out_fault = out_valid ? w_q_head.fault : 1'b0;

    always_comb begin
        w_push_ent = '0;
        if (w_fault_push) begin
            w_push_ent.fault = 1'b1;
            w_push_ent.pc4   = r_fault_pc4;
            w_push_ent.instr = INSTR_NOP;
        end else begin
            w_push_ent.fault = 1'b0;
            w_push_ent.pc4   = w_tag_head;
            w_push_ent.instr = imem_resp_data;
        end
    end
`else
    logic w_unused_pc_lo;

    assign w_unused_pc_lo = &{1'b0, redirect_pc[1:0]};
    assign w_run          = 1'b1;
    assign w_q_push       = w_resp_keep;

    always_comb begin
        w_push_ent       = '0;
        w_push_ent.pc4   = w_tag_head;
        w_push_ent.instr = imem_resp_data;
    end
`endif

    // Tags follow every accepted request and retire with its response, kept or dropped.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_fire),
        .i_push_dat (pc_next(r_fetch_pc)),
        .i_pop      (w_resp),
        .i_flush    (1'b0),
        .o_head_dat (w_tag_head),
        .o_count    (w_tag_cnt_unused)
    );

    fetch_queue #(
        .WIDTH ($bits(qentry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_q_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .i_flush    (redirect),
        .o_head_dat (w_q_head),
        .o_count    (w_q_count)
    );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the IF/ID pipeline register and decode.
- Owns the program counter and issues in-order requests to instruction memory over a valid/ready request channel with a variable-latency response channel.
- Buffers returned words in a small queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 4: queue entries; also the maximum number of outstanding plus buffered fetches. Must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000: fetch address loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  fetch address; equals the internal fetch_pc.
- imem_resp_valid  input  1  response word valid. Responses arrive in request order, at least 1 cycle after the accepting handshake.
- imem_resp_data  input  32  instruction word.
- redirect  input  1  taken branch/jump from a later stage; one-cycle pulse.
- redirect_pc  input  32  new fetch address.
- out_valid  output  1  queue head valid toward decode.
- out_ready  input  1  decode accepts the head.
- out_instr  output  32  head instruction; 0 when out_valid==0.
- out_pc4  output  32  address of the head instruction + 4; 0 when out_valid==0.

Behaviour:
- Reset:
  - fetch_pc=RESET_PC.
  - Queue count, outstanding counter and discard counter all 0.
  - imem_req_valid=0, out_valid=0, out_instr=0, out_pc4=0.
- Request issue:
  - imem_req_valid = (count + outstanding < DEPTH) && !redirect.
  - A request fires on valid && ready. The address is not required to be held across non-ready cycles.
- On fire:
  - fetch_pc <= fetch_pc + 4, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
  - outstanding increments.
  - The entry's pc4 (addr+4) is pushed to an internal tag FIFO of DEPTH entries.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If discard > 0: the word is dropped, discard decrements, and the tag is popped.
  - Otherwise the word and its tag are pushed into the queue.
  - A response with outstanding==0 is a protocol error and is ignored.
- Decode handshake:
  - out_valid = (count != 0).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - The queue can never overflow: the credit rule guarantees it.
- Redirect cycle, which takes priority over everything else:
  - fetch_pc <= redirect_pc.
  - Queue count <= 0; a same-cycle pop or push is discarded.
  - discard <= outstanding + fire - resp_valid.
  - outstanding is updated normally.
  - A response arriving in the redirect cycle belongs to the old stream and is dropped.
- Latency:
  - Response to out_valid: 1 cycle (registered queue write).
  - Redirect to first new request: 1 cycle.
- Reset asserted mid-operation: all state returns to reset values. In-flight memory responses are the memory's responsibility; memory is reset by the same signal.
- redirect_pc[1:0] != 0: the low two bits are forced to 0, unless the optional feature below is enabled.

Optional Feature:
- Macro: FETCH_ALIGN_TRAP_EN.
- When defined:
  - Adds output out_fault (1 bit).
  - A misaligned redirect enters state FAULT: no further requests; in-flight responses are discarded.
  - Once discard reaches 0, a single entry is enqueued with instr=32'h0 (NOP), pc4=redirect_pc+4 and fault=1.
  - The block stays in FAULT until the next aligned redirect, which returns it to RUN.
  - out_fault is 0 on reset and whenever out_valid==0.
- When undefined: no port, no FAULT state; address bits [1:0] are forced to 0.

Decomposition:
- Shared defines header (cpu_defs), alongside the control opcode constants:
  - INSTR_NOP=32'h0.
  - DEFAULT_RESET_PC.
  - Word width 32.
  - Fetch state encodings RUN=1'b0, FAULT=1'b1.
- One sub-module: fetch_queue, a synchronous DEPTH-entry FIFO with push, pop, flush and count. It is instantiated twice: once as the tag FIFO (32 bits) and once as the instruction queue (64 bits: instr and pc4, plus 1 bit for fault under the macro).

Test Plan:
- Reset release, ready=1, 1-cycle response latency, out_ready=1:
  - Requests at 0x0, 0x4, 0x8 on consecutive cycles.
  - out_pc4 sequence 0x4, 0x8, 0xC with matching data.
- out_ready=0, memory always ready:
  - Exactly 4 requests issue, then imem_req_valid=0.
  - out_valid=1 with the head at pc4=0x4.
  - One pop frees one credit; the next request goes to 0x10.
- 3-cycle response latency, redirect to 0x100 with 2 requests outstanding:
  - Both old responses are dropped.
  - The first out_pc4 after the redirect is 0x104.
- Redirect in the same cycle as a response and a pop:
  - count=0 next cycle.
  - The response word never appears at the output.
- fetch_pc=0xFFFF_FFFC: the next request address is 0x0000_0000.
- Under FETCH_ALIGN_TRAP_EN, redirect to 0x202:
  - One entry appears with out_fault=1, out_instr=0, out_pc4=0x206.
  - No requests until a redirect to 0x300 resumes fetching.
